// File: rtl/prg_inject.sv
// prg_inject: streams a PRG file from hps_io into RAM.
// The first two file bytes are the little-endian load address. Each later byte is
// written to load_addr + offset - 2. When a load at BASIC_START finishes without
// error, six zero-page bytes at PTR_BASE..PTR_BASE+5 are set to the end address,
// filling the VARTAB, ARYTAB and STREND pointers.
//
// Ports
//   clk_sys        in   system clock, posedge only
//   reset          in   synchronous active-high reset
//   ioctl_download in   download in progress
//   ioctl_index    in   download target index; only INDEX is handled
//   ioctl_wr       in   one-cycle byte strobe
//   ioctl_addr     in   byte offset in the file
//   ioctl_dout     in   file byte
//   ioctl_wait     out  backpressure; no new ioctl_wr while high
//   dma_addr       out  RAM write address
//   dma_din        out  RAM write data
//   dma_we         out  one-cycle RAM write strobe
//   busy           out  high from download start until fixup is done
//   error          out  sticky error flag
module prg_inject #(
  parameter logic [7:0]  INDEX       = 8'h41,
  parameter logic [15:0] BASIC_START = 16'h0401,
  parameter logic [7:0]  PTR_BASE    = 8'h2A,
  parameter logic [15:0] MAX_ADDR    = 16'h7FFF
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic [15:0] dma_addr,
  output logic [7:0]  dma_din,
  output logic        dma_we,
  output logic        busy,
  output logic        error
);

  typedef enum logic [2:0] {StIdle, StHdrLo, StHdrHi, StData, StFix, StDone} state_e;

  state_e      state_q, state_d;
  logic        active_q;
  logic        pend_q, pend_d;
  logic [15:0] load_addr_q, load_addr_d;
  logic [15:0] end_addr_q, end_addr_d;
  logic [2:0]  fix_cnt_q, fix_cnt_d;
  logic        dma_we_q, dma_we_d;
  logic [15:0] dma_addr_q, dma_addr_d;
  logic [7:0]  dma_din_q, dma_din_d;
  logic        wait_q, wait_d;
  logic        busy_q, busy_d;
  logic        error_q, error_d;

  logic        active, dl_rise, dl_fall, wr_ok, wr_viol, start, do_fix, addr_bad;
  logic [25:0] eff_addr;
  logic [7:0]  fix_ptr;

  assign active  = ioctl_download && (ioctl_index == INDEX);
  assign dl_rise = active && !active_q;
  assign dl_fall = !active && active_q;
  assign wr_ok   = active && ioctl_wr && !wait_q;
  assign wr_viol = active && ioctl_wr && wait_q;
  assign start   = (state_q == StIdle) && (dl_rise || pend_q);
  assign do_fix  = (load_addr_q == BASIC_START) && !error_q;

  // Wide sum so that both a carry past $FFFF and an offset below 2 show up in the
  // upper bits.
  assign eff_addr = {10'd0, load_addr_q} + {1'b0, ioctl_addr} - 26'd2;
  assign addr_bad = (eff_addr[25:16] != 10'd0) || (eff_addr[15:0] > MAX_ADDR);
  assign fix_ptr  = PTR_BASE + {5'd0, fix_cnt_q};

  // State register
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StHdrLo;
      StHdrLo: begin
        if (dl_fall)    state_d = StDone;
        else if (wr_ok) state_d = StHdrHi;
      end
      StHdrHi: begin
        if (dl_fall)    state_d = StDone;
        else if (wr_ok) state_d = StData;
      end
      StData:  if (dl_fall) state_d = do_fix ? StFix : StDone;
      StFix:   if (fix_cnt_q == 3'd5) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output and datapath next-state logic
  always_comb begin
    pend_d      = pend_q;
    load_addr_d = load_addr_q;
    end_addr_d  = end_addr_q;
    fix_cnt_d   = fix_cnt_q;
    dma_we_d    = 1'b0;
    dma_addr_d  = dma_addr_q;
    dma_din_d   = dma_din_q;
    wait_d      = 1'b0;
    busy_d      = busy_q;
    error_d     = error_q;

    // A download that starts during fixup or DONE is held until IDLE.
    if (dl_rise && (state_q != StIdle)) pend_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          pend_d    = 1'b0;
          error_d   = 1'b0;
          busy_d    = 1'b1;
          fix_cnt_d = 3'd0;
        end
      end
      StHdrLo: begin
        if (dl_fall)    error_d = 1'b1;
        else if (wr_ok) load_addr_d[7:0] = ioctl_dout;
      end
      StHdrHi: begin
        if (dl_fall)    error_d = 1'b1;
        else if (wr_ok) load_addr_d[15:8] = ioctl_dout;
      end
      StData: begin
        if (wr_ok) begin
          wait_d = 1'b1;
          if (addr_bad) begin
            error_d = 1'b1;
          end else begin
            dma_we_d   = 1'b1;
            dma_addr_d = eff_addr[15:0];
            dma_din_d  = ioctl_dout;
            end_addr_d = eff_addr[15:0] + 16'd1;
          end
        end
        if (dl_fall && do_fix) wait_d = 1'b1;
      end
      StFix: begin
        wait_d     = 1'b1;
        dma_we_d   = 1'b1;
        dma_addr_d = {8'h00, fix_ptr};
        dma_din_d  = fix_cnt_q[0] ? end_addr_q[15:8] : end_addr_q[7:0];
        fix_cnt_d  = fix_cnt_q + 3'd1;
      end
      StDone: begin
        busy_d = 1'b0;
      end
      default: ;
    endcase

    if (wr_viol && !start) error_d = 1'b1;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      // Treat the download as already running so that bytes arriving after a reset
      // are ignored until ioctl_download rises again.
      active_q    <= 1'b1;
      pend_q      <= 1'b0;
      load_addr_q <= 16'h0000;
      end_addr_q  <= 16'h0000;
      fix_cnt_q   <= 3'd0;
      dma_we_q    <= 1'b0;
      dma_addr_q  <= 16'h0000;
      dma_din_q   <= 8'h00;
      wait_q      <= 1'b0;
      busy_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      active_q    <= active;
      pend_q      <= pend_d;
      load_addr_q <= load_addr_d;
      end_addr_q  <= end_addr_d;
      fix_cnt_q   <= fix_cnt_d;
      dma_we_q    <= dma_we_d;
      dma_addr_q  <= dma_addr_d;
      dma_din_q   <= dma_din_d;
      wait_q      <= wait_d;
      busy_q      <= busy_d;
      error_q     <= error_d;
    end
  end

  assign ioctl_wait = wait_q;
  assign dma_addr   = dma_addr_q;
  assign dma_din    = dma_din_q;
  assign dma_we     = dma_we_q;
  assign busy       = busy_q;
  assign error      = error_q;

endmodule

// File: tb/tb_prg_inject.sv
module tb_prg_inject;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic [15:0] dma_addr;
  logic [7:0]  dma_din;
  logic        dma_we;
  logic        busy;
  logic        error;

  always #5 clk_sys = ~clk_sys;

  prg_inject dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .dma_addr       (dma_addr),
    .dma_din        (dma_din),
    .dma_we         (dma_we),
    .busy           (busy),
    .error          (error)
  );

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  localparam int Hdr = 0;
  localparam int Wr  = 1;
  localparam int Sup = 2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every RAM write must match the oldest expected write.
  always @(negedge clk_sys) begin
    if (dma_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $error("FAIL unexpected_we: observed %h=%h expected no write", dma_addr, dma_din);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("dma_write", {8'h00, dma_addr, dma_din}, {8'h00, e.a, e.d});
      end
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic send(input logic [24:0] a, input logic [7:0] d, input int kind,
                      input logic [15:0] ea, input string tag);
    wr_t e;
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    if (kind == Wr) begin
      e.a = ea;
      e.d = d;
      exp_q.push_back(e);
    end
    tick();
    ioctl_wr = 1'b0;
    chk({tag, "_we"}, {31'd0, dma_we}, {31'd0, kind == Wr});
    if (kind == Wr) chk({tag, "_wait_hi"}, {31'd0, ioctl_wait}, 32'd1);
    tick();
    chk({tag, "_wait_lo"}, {31'd0, ioctl_wait}, 32'd0);
    tick();
  endtask

  task automatic push_fix(input logic [15:0] end_addr);
    wr_t e;
    for (int i = 0; i < 6; i++) begin
      e.a = 16'h002A + 16'(i);
      e.d = (i % 2 == 0) ? end_addr[7:0] : end_addr[15:8];
      exp_q.push_back(e);
    end
  endtask

  task automatic start_dl(input logic [7:0] idx);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    tick();
    tick();
  endtask

  task automatic end_dl(input logic exp_err, input string tag);
    int n;
    ioctl_download = 1'b0;
    n = 0;
    tick();
    while (busy === 1'b1 && n < 30) begin
      tick();
      n++;
    end
    chk({tag, "_busy_lo"}, {31'd0, busy}, 32'd0);
    chk({tag, "_error"}, {31'd0, error}, {31'd0, exp_err});
    chk({tag, "_pending"}, exp_q.size(), 32'd0);
    chk({tag, "_wait"}, {31'd0, ioctl_wait}, 32'd0);
    tick();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_we"}, {31'd0, dma_we}, 32'd0);
    chk({tag, "_wait"}, {31'd0, ioctl_wait}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_error"}, {31'd0, error}, 32'd0);
    chk({tag, "_addr"}, {16'd0, dma_addr}, 32'd0);
    chk({tag, "_din"}, {24'd0, dma_din}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    wr_t e;
    reset          = 1'b1;
    ioctl_download = 1'b0;
    ioctl_index    = 8'h41;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    tick();
    tick();
    chk_reset("por");
    reset = 1'b0;
    tick();

    // BASIC load at $0401 with pointer fixup
    start_dl(8'h41);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    send(25'd0, 8'h01, Hdr, 16'h0, "t1_h0");
    send(25'd1, 8'h04, Hdr, 16'h0, "t1_h1");
    send(25'd2, 8'hAA, Wr, 16'h0401, "t1_d0");
    send(25'd3, 8'hBB, Wr, 16'h0402, "t1_d1");
    send(25'd4, 8'hCC, Wr, 16'h0403, "t1_d2");
    push_fix(16'h0404);
    end_dl(1'b0, "t1");

    // Non-BASIC load: no fixup
    start_dl(8'h41);
    send(25'd0, 8'h00, Hdr, 16'h0, "t2_h0");
    send(25'd1, 8'h10, Hdr, 16'h0, "t2_h1");
    send(25'd2, 8'h11, Wr, 16'h1000, "t2_d0");
    send(25'd3, 8'h22, Wr, 16'h1001, "t2_d1");
    end_dl(1'b0, "t2");

    // Overrun past MAX_ADDR
    start_dl(8'h41);
    send(25'd0, 8'hFE, Hdr, 16'h0, "t3_h0");
    send(25'd1, 8'h7F, Hdr, 16'h0, "t3_h1");
    send(25'd2, 8'h01, Wr, 16'h7FFE, "t3_d0");
    send(25'd3, 8'h02, Wr, 16'h7FFF, "t3_d1");
    send(25'd4, 8'h03, Sup, 16'h0, "t3_d2");
    end_dl(1'b1, "t3");

    // Short file; error from the previous load must clear at start
    start_dl(8'h41);
    chk("t4_err_clr", {31'd0, error}, 32'd0);
    send(25'd0, 8'h01, Hdr, 16'h0, "t4_h0");
    end_dl(1'b1, "t4");

    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();

    // Foreign index is ignored
    start_dl(8'h01);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    send(25'd0, 8'h01, Hdr, 16'h0, "t5_b0");
    send(25'd1, 8'h04, Hdr, 16'h0, "t5_b1");
    send(25'd2, 8'hAA, Hdr, 16'h0, "t5_b2");
    end_dl(1'b0, "t5");

    // Reset in the middle of a BASIC load
    start_dl(8'h41);
    send(25'd0, 8'h01, Hdr, 16'h0, "t6_h0");
    send(25'd1, 8'h04, Hdr, 16'h0, "t6_h1");
    send(25'd2, 8'hAA, Wr, 16'h0401, "t6_d0");
    send(25'd3, 8'hBB, Wr, 16'h0402, "t6_d1");
    reset = 1'b1;
    tick();
    chk_reset("t6_rst");
    reset = 1'b0;
    tick();
    send(25'd4, 8'hCC, Hdr, 16'h0, "t6_late");
    chk("t6_busy", {31'd0, busy}, 32'd0);
    end_dl(1'b0, "t6");

    // Write during ioctl_wait, then a non-sequential offset
    start_dl(8'h41);
    send(25'd0, 8'h01, Hdr, 16'h0, "t7_h0");
    send(25'd1, 8'h04, Hdr, 16'h0, "t7_h1");
    send(25'd2, 8'h11, Wr, 16'h0401, "t7_d0");
    e.a = 16'h0402;
    e.d = 8'h22;
    exp_q.push_back(e);
    ioctl_addr = 25'd3;
    ioctl_dout = 8'h22;
    ioctl_wr   = 1'b1;
    tick();
    chk("t7_first_we", {31'd0, dma_we}, 32'd1);
    ioctl_addr = 25'd4;
    ioctl_dout = 8'h33;
    tick();
    ioctl_wr = 1'b0;
    chk("t7_viol_we", {31'd0, dma_we}, 32'd0);
    chk("t7_viol_err", {31'd0, error}, 32'd1);
    tick();
    send(25'd9, 8'h44, Wr, 16'h0408, "t7_skip");
    end_dl(1'b1, "t7");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
